// File: rtl/rom_stream_reader_if.sv
// Bundle of the sequencer's request, ROM and output-stream signals.
// The checksum member exists only when ROM_STREAM_CHECKSUM_EN is defined.
interface rom_stream_reader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 10
);
   logic              start;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_cs;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
`ifdef ROM_STREAM_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;

   modport master (
      input  start, rom_data, out_ready,
      output busy, done, rom_addr, rom_cs, out_data, out_valid, checksum
   );
   modport slave (
      output start, rom_data, out_ready,
      input  busy, done, rom_addr, rom_cs, out_data, out_valid, checksum
   );
`else
   modport master (
      input  start, rom_data, out_ready,
      output busy, done, rom_addr, rom_cs, out_data, out_valid
   );
   modport slave (
      output start, rom_data, out_ready,
      input  busy, done, rom_addr, rom_cs, out_data, out_valid
   );
`endif
endinterface

// File: rtl/rom_stream_reader.sv
// Sweeps ROM addresses 0..NUM_WORDS-1 on a start pulse and streams each word out.
// Optional running checksum of streamed words: define ROM_STREAM_CHECKSUM_EN.
module rom_stream_reader #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 10,
   parameter int NUM_WORDS = 10
) (
   input  logic                clk,
   input  logic                rst,
   rom_stream_reader_if.master bus,
   output logic [2:0]          o_dbg_state
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ADDR    = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_OUT     = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              w_handshake;

   // Output stream: a word transfers on the rising edge where out_valid and
   // out_ready are both high; out_data and out_valid hold until that edge.
   assign w_handshake = r_valid & bus.out_ready;

`ifdef ROM_STREAM_CHECKSUM_EN
   logic [DATA_W-1:0] r_sum;
   assign bus.checksum = r_sum;
`endif

   // r_addr doubles as the word counter: word k is read from address k.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
`ifdef ROM_STREAM_CHECKSUM_EN
         r_sum   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_addr  <= '0;
                  r_state <= S_ADDR;
`ifdef ROM_STREAM_CHECKSUM_EN
                  r_sum   <= '0;
`endif
               end
            end
            S_ADDR: r_state <= S_CAPTURE;
            S_CAPTURE: begin
               r_data  <= bus.rom_data;
               r_valid <= 1'b1;
               r_state <= S_OUT;
            end
            S_OUT: begin
               if (w_handshake) begin
                  r_valid <= 1'b0;
`ifdef ROM_STREAM_CHECKSUM_EN
                  r_sum   <= r_sum + r_data;
`endif
                  if (r_addr == LAST_ADDR) begin
                     r_state <= S_DONE;
                  end else begin
                     r_addr  <= r_addr + ADDR_W'(1);
                     r_state <= S_ADDR;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.rom_addr  = r_addr;
   assign bus.rom_cs    = (r_state == S_ADDR) || (r_state == S_CAPTURE) || (r_state == S_OUT);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = (r_state == S_DONE);
   assign bus.out_data  = r_data;
   assign bus.out_valid = r_valid;
   assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: directed sweeps with a data/cycle scoreboard.
// Also covers a NUM_WORDS=1 instance and, when compiled with it, the checksum.
module tb_rom_stream_reader;
   localparam int AW = 4;
   localparam int DW = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rom_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
   rom_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   logic [2:0] dbg, dbg1;

   logic [DW-1:0] rom_tbl [0:15];
   initial begin
      rom_tbl[0]  = 10'h100; rom_tbl[1]  = 10'h101; rom_tbl[2]  = 10'h102; rom_tbl[3]  = 10'h103;
      rom_tbl[4]  = 10'h104; rom_tbl[5]  = 10'h105; rom_tbl[6]  = 10'h106; rom_tbl[7]  = 10'h107;
      rom_tbl[8]  = 10'h108; rom_tbl[9]  = 10'h109; rom_tbl[10] = 10'h3FF; rom_tbl[11] = 10'h3FF;
      rom_tbl[12] = 10'h3FF; rom_tbl[13] = 10'h3FF; rom_tbl[14] = 10'h3FF; rom_tbl[15] = 10'h3FF;
   end

   // ROM returns zeros when not selected so a missing chip select is visible.
   assign bus.rom_data  = bus.rom_cs  ? rom_tbl[bus.rom_addr]  : '0;
   assign bus1.rom_data = bus1.rom_cs ? rom_tbl[bus1.rom_addr] : '0;

   rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(10)) u_dut (
      .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg)
   );
   rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(1)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .o_dbg_state(dbg1)
   );

   // Scoreboard
   logic [DW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   int            t0 = 0;
   int            n_tests = 0;
   int            n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per handshake seen on the output stream.
   always @(negedge clk) begin
      logic [DW-1:0] ed;
      int            ec;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_word: got 0x%0h expected none", bus.out_data);
         end else begin
            ed = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("word_data", bus.out_data, ed);
            if (ec >= 0) check("word_cycle", cyc - t0, ec);
         end
      end
      if (bus.rom_cs) check("rom_addr_in_range", 32'(bus.rom_addr <= 4'd9), 1);
   end

   task automatic run_sweep(input int stall_word, input int stall_len,
                            input bit extra_starts, input int rst_word);
      int            rel, done_rel, dcount, n_push, exp_done, ec, st_lo;
      logic [DW-1:0] sum;
      bit            fin;
      n_push   = (rst_word >= 0) ? rst_word : 10;
      sum      = '0;
      st_lo    = 3 + 3 * stall_word;
      exp_done = 31 + ((stall_word >= 0) ? stall_len : 0);
      for (int k = 0; k < n_push; k++) begin
         exp_q.push_back(rom_tbl[k]);
         sum = sum + rom_tbl[k];
         ec  = 3 + 3 * k;
         if (stall_word >= 0 && k >= stall_word) ec += stall_len;
         exp_cyc_q.push_back(ec);
      end
      @(posedge clk); #1;
      t0            = cyc;
      bus.start     = 1'b1;
      bus.out_ready = 1'b1;
      rel = 0; done_rel = -1; dcount = 0; fin = 1'b0;
      while (!fin) begin
         @(posedge clk); #1;
         rel           = cyc - t0;
         bus.start     = extra_starts && (rel == 4 || rel == 31);
         bus.out_ready = !(stall_word >= 0 && rel >= st_lo && rel < st_lo + stall_len);
         if (stall_word >= 0 && rel >= st_lo && rel < st_lo + stall_len) begin
            check("stall_data",  bus.out_data, rom_tbl[stall_word]);
            check("stall_valid", bus.out_valid, 1);
            check("stall_addr",  bus.rom_addr, stall_word);
         end
         if (rst_word >= 0 && rel == 3 + 3 * rst_word) begin
            check("pre_rst_valid", bus.out_valid, 1);
            bus.out_ready = 1'b0;
            rst           = 1'b1;
         end
         if (rst_word >= 0 && rel == 4 + 3 * rst_word) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_rom_cs",    bus.rom_cs, 0);
            check("rst_busy",      bus.busy, 0);
            check("rst_rom_addr",  bus.rom_addr, 0);
            check("rst_out_data",  bus.out_data, 0);
            check("rst_dbg_state", dbg, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
            check("rst_checksum",  bus.checksum, 0);
`endif
            rst = 1'b0;
            fin = 1'b1;
         end
         if (bus.done) begin
            dcount++;
            if (done_rel < 0) done_rel = rel;
`ifdef ROM_STREAM_CHECKSUM_EN
            check("checksum_at_done", bus.checksum, sum);
`endif
         end
         if (done_rel >= 0 && rel == done_rel + 1) check("busy_after_done", bus.busy, 0);
         if (done_rel >= 0 && rel == done_rel + 3) begin
            check("busy_stays_low", bus.busy, 0);
            fin = 1'b1;
         end
         if (rel >= 300 && !fin) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL sweep_timeout: got no done by cycle %0d expected done at %0d", rel, exp_done);
            fin = 1'b1;
         end
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      if (rst_word < 0) begin
         check("done_cycle", done_rel, exp_done);
         check("done_count", dcount, 1);
      end else begin
         check("no_done_on_rst", dcount, 0);
      end
      check("scoreboard_empty", exp_q.size(), 0);
      exp_q.delete();
      exp_cyc_q.delete();
   endtask

   initial begin
      int done_rel1;
      int rel;
      bus.start = 1'b0;  bus.out_ready = 1'b1;
      bus1.start = 1'b0; bus1.out_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_rom_cs",    bus.rom_cs, 0);
      check("reset_busy",      bus.busy, 0);
      check("reset_done",      bus.done, 0);
      check("reset_rom_addr",  bus.rom_addr, 0);
      check("reset_out_data",  bus.out_data, 0);
      check("reset_dbg_state", dbg, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
      check("reset_checksum",  bus.checksum, 0);
`endif
      rst = 1'b0;
      repeat (2) @(posedge clk);

      run_sweep(-1, 0, 1'b0, -1);  // full sweep, no backpressure
      run_sweep(3, 5, 1'b0, -1);   // word 3 held 5 cycles
      run_sweep(-1, 0, 1'b1, -1);  // starts at cycles 4 and 31 ignored
      run_sweep(-1, 0, 1'b0, 5);   // reset while word 5 is waiting
      run_sweep(-1, 0, 1'b0, -1);  // clean sweep after reset starts at 0x100

      // Single-word instance
      @(posedge clk); #1;
      t0 = cyc;
      bus1.start = 1'b1;
      done_rel1  = -1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         rel        = cyc - t0;
         bus1.start = 1'b0;
         if (rel == 3) begin
            check("n1_valid", bus1.out_valid, 1);
            check("n1_data",  bus1.out_data, 10'h100);
         end
         if (bus1.done && done_rel1 < 0) begin
            done_rel1 = rel;
`ifdef ROM_STREAM_CHECKSUM_EN
            check("n1_checksum", bus1.checksum, 10'h100);
`endif
         end
      end
      check("n1_done_cycle", done_rel1, 4);
      check("n1_idle", bus1.busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
